// File: rtl/ps2_pkg.sv
// Shared constants and types for the PS/2 scancode sequencer.
package ps2_pkg;

  localparam logic [7:0] PS2_EXT  = 8'hE0;
  localparam logic [7:0] PS2_BRK  = 8'hF0;
  localparam logic [7:0] PS2_ERR0 = 8'h00;
  localparam logic [7:0] PS2_ERR1 = 8'hFF;

  // Bit 0 = extended prefix seen, bit 1 = break prefix seen.
  typedef enum logic [1:0] {
    IDLE    = 2'b00,
    EXT     = 2'b01,
    BRK     = 2'b10,
    EXT_BRK = 2'b11
  } ps2_state_e;

  typedef struct packed {
    logic       ext;
    logic       rel;
    logic [7:0] code;
  } ps2_evt_t;

endpackage

// File: rtl/ps2_key_ctrl_if.sv
// Byte input and event output handshake of the scancode sequencer.
interface ps2_key_ctrl_if;

  logic       in_valid;
  logic [7:0] in_data;
  logic       in_err;
  logic       out_valid;
  logic       out_ready;
  logic       out_ext;
  logic       out_release;
  logic [7:0] out_code;

  modport master (
    output in_valid, in_data, in_err, out_ready,
    input  out_valid, out_ext, out_release, out_code
  );

  modport slave (
    input  in_valid, in_data, in_err, out_ready,
    output out_valid, out_ext, out_release, out_code
  );

endinterface

// File: rtl/ps2_evt_fifo.sv
// Generic synchronous FIFO; push ignored when full unless a pop frees the slot in the same cycle.
// Head data is registered and reads as zero while empty.
module ps2_evt_fifo #(
  parameter int WIDTH = 10,
  parameter int DEPTH = 8,
  parameter int CW    = $clog2(DEPTH) + 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push_i,
  input  logic [WIDTH-1:0] wdata_i,
  input  logic             pop_i,
  output logic [WIDTH-1:0] rdata_o,
  output logic             full_o,
  output logic             empty_o,
  output logic [CW-1:0]    count_o
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q, rd_ptr_q;
  logic [CW-1:0]    count_q;
  logic             do_push, do_pop;

  assign full_o  = (count_q == CW'(DEPTH));
  assign empty_o = (count_q == '0);
  assign do_pop  = pop_i & ~empty_o;
  assign do_push = push_i & (~full_o | do_pop);
  assign count_o = count_q;
  assign rdata_o = empty_o ? '0 : mem_q[rd_ptr_q];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (do_push) wr_ptr_q <= wr_ptr_q + AW'(1);
      if (do_pop)  rd_ptr_q <= rd_ptr_q + AW'(1);
      case ({do_push, do_pop})
        2'b10:   count_q <= count_q + CW'(1);
        2'b01:   count_q <= count_q - CW'(1);
        default: count_q <= count_q;
      endcase
    end
  end

  // Storage needs no reset: the head is masked while empty.
  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q] <= wdata_i;
  end

endmodule

// File: rtl/ps2_key_ctrl.sv
// Folds E0/F0 prefix bytes into make/break key events and queues them for a ready/valid consumer.
// Events reach the head on the edge that accepts the final byte; a full queue drops new events and sets overflow.
module ps2_key_ctrl
  import ps2_pkg::*;
#(
  parameter int DEPTH = 8,
  parameter int CW    = $clog2(DEPTH) + 1
) (
  input  logic          clk,
  input  logic          resetn,
  ps2_key_ctrl_if.slave bus,
  output logic [CW-1:0] count,
  output logic          overflow,
  input  logic          clr_ovf
);

  ps2_state_e state_q, state_d;
  ps2_evt_t   evt_d, head;
  logic       emit, pop, full, empty, drop;
  logic       overflow_q, overflow_d;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q    <= IDLE;
      overflow_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      overflow_q <= overflow_d;
    end
  end

  // Prefixes accumulate as flag bits of the state encoding.
  always_comb begin
    state_d = state_q;
    emit    = 1'b0;
    evt_d   = '0;
    if (bus.in_err) begin
      state_d = IDLE;
    end else if (bus.in_valid) begin
      case (bus.in_data)
        PS2_EXT:            state_d = ps2_state_e'(state_q | EXT);
        PS2_BRK:            state_d = ps2_state_e'(state_q | BRK);
        PS2_ERR0, PS2_ERR1: state_d = IDLE;
        default: begin
          emit       = 1'b1;
          evt_d.ext  = state_q[0];
          evt_d.rel  = state_q[1];
          evt_d.code = bus.in_data;
          state_d    = IDLE;
        end
      endcase
    end
  end

  assign pop        = bus.out_valid & bus.out_ready;
  assign drop       = emit & full & ~pop;
  assign overflow_d = (overflow_q & ~clr_ovf) | drop;
  assign overflow   = overflow_q;

  ps2_evt_fifo #(
    .WIDTH ($bits(ps2_evt_t)),
    .DEPTH (DEPTH),
    .CW    (CW)
  ) u_fifo (
    .clk     (clk),
    .rst_n   (resetn),
    .push_i  (emit),
    .wdata_i (evt_d),
    .pop_i   (pop),
    .rdata_o (head),
    .full_o  (full),
    .empty_o (empty),
    .count_o (count)
  );

  assign bus.out_valid   = ~empty;
  assign bus.out_ext     = head.ext;
  assign bus.out_release = head.rel;
  assign bus.out_code    = head.code;

endmodule
